// File: rtl/maze_pkg.sv
// Shared maze map geometry, starvation limit and arbiter state encoding.
package maze_pkg;

  localparam int unsigned ROWS         = 20;
  localparam int unsigned COLS         = 30;
  localparam int unsigned ADDR_W       = 5;
  localparam int unsigned STARVE_LIMIT = 4;
  localparam int unsigned STARVE_W     = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT_D = 2'd1,
    WAIT_M = 2'd2
  } state_e;

  function automatic logic row_oor(input logic [ADDR_W-1:0] row);
    return row >= ADDR_W'(ROWS);
  endfunction

  function automatic logic col_oor(input logic [ADDR_W-1:0] col);
    return col >= ADDR_W'(COLS);
  endfunction

endpackage

// File: rtl/maze_map_arbiter_if.sv
// Bundle of both requester handshakes plus the map ROM bus.
interface maze_map_arbiter_if;
  import maze_pkg::*;

  logic              disp_req;
  logic [ADDR_W-1:0] disp_row;
  logic              disp_gnt;
  logic              disp_valid;
  logic [COLS-1:0]   disp_data;

  logic              mv_req;
  logic [ADDR_W-1:0] mv_row;
  logic [ADDR_W-1:0] mv_col;
  logic              mv_gnt;
  logic              mv_valid;
  logic              mv_wall;

  logic [ADDR_W-1:0] rom_addr;
  logic [COLS-1:0]   rom_data;
  logic              busy;

  // Requesters and the ROM side.
  modport master (
    output disp_req, disp_row, mv_req, mv_row, mv_col, rom_data,
    input  disp_gnt, disp_valid, disp_data, mv_gnt, mv_valid, mv_wall, rom_addr, busy
  );

  // The arbiter.
  modport slave (
    input  disp_req, disp_row, mv_req, mv_row, mv_col, rom_data,
    output disp_gnt, disp_valid, disp_data, mv_gnt, mv_valid, mv_wall, rom_addr, busy
  );

endinterface

// File: rtl/maze_map_arbiter.sv
// Shares the maze map ROM between the VGA row fetcher and the move wall check;
// display has priority, a starve counter forces a move grant after a bounded run.
module maze_map_arbiter
  import maze_pkg::*;
#(
  parameter int unsigned ROM_LAT = 1
) (
  input logic              Clk,
  input logic              Reset,
  maze_map_arbiter_if.slave bus
);

  localparam int unsigned      LAT_W    = (ROM_LAT > 1) ? $clog2(ROM_LAT + 1) : 1;
  localparam logic [ADDR_W-1:0] LAST_COL = ADDR_W'(COLS - 1);

  state_e              state_q, state_d;
  logic [LAT_W-1:0]    lat_q, lat_d;
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
  logic [ADDR_W-1:0]   col_q, col_d;
  logic                oor_q, oor_d;
  logic                disp_gnt_q, disp_gnt_d;
  logic                mv_gnt_q, mv_gnt_d;
  logic                disp_valid_q, disp_valid_d;
  logic                mv_valid_q, mv_valid_d;
  logic [COLS-1:0]     disp_data_q, disp_data_d;
  logic                mv_wall_q, mv_wall_d;

  logic starved, pick_mv, disp_oor, mv_oor;

  assign starved  = starve_q == STARVE_W'(STARVE_LIMIT);
  assign pick_mv  = bus.mv_req && (!bus.disp_req || starved);
  assign disp_oor = row_oor(bus.disp_row);
  assign mv_oor   = row_oor(bus.mv_row) || col_oor(bus.mv_col);

  always_comb begin
    state_d      = state_q;
    lat_d        = lat_q;
    starve_d     = bus.mv_req ? starve_q : '0;
    rom_addr_d   = rom_addr_q;
    col_d        = col_q;
    oor_d        = oor_q;
    disp_gnt_d   = 1'b0;
    mv_gnt_d     = 1'b0;
    disp_valid_d = 1'b0;
    mv_valid_d   = 1'b0;
    disp_data_d  = disp_data_q;
    mv_wall_d    = mv_wall_q;

    unique case (state_q)
      IDLE: begin
        if (pick_mv) begin
          state_d    = WAIT_M;
          mv_gnt_d   = 1'b1;
          lat_d      = LAT_W'(ROM_LAT);
          oor_d      = mv_oor;
          col_d      = bus.mv_col;
          starve_d   = '0;
          if (!mv_oor) rom_addr_d = bus.mv_row;
        end else if (bus.disp_req) begin
          state_d    = WAIT_D;
          disp_gnt_d = 1'b1;
          lat_d      = LAT_W'(ROM_LAT);
          oor_d      = disp_oor;
          if (!disp_oor) rom_addr_d = bus.disp_row;
          if (bus.mv_req && !starved) starve_d = starve_q + STARVE_W'(1);
        end
      end
      WAIT_D: begin
        if (lat_q == '0) begin
          state_d      = IDLE;
          disp_valid_d = 1'b1;
          disp_data_d  = oor_q ? '1 : bus.rom_data;
        end else begin
          lat_d = lat_q - LAT_W'(1);
        end
      end
      WAIT_M: begin
        if (lat_q == '0) begin
          state_d    = IDLE;
          mv_valid_d = 1'b1;
          // Column 0 is the row's MSB.
          mv_wall_d  = oor_q ? 1'b1 : bus.rom_data[LAST_COL - col_q];
        end else begin
          lat_d = lat_q - LAT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q      <= IDLE;
      lat_q        <= '0;
      starve_q     <= '0;
      rom_addr_q   <= '0;
      col_q        <= '0;
      oor_q        <= 1'b0;
      disp_gnt_q   <= 1'b0;
      mv_gnt_q     <= 1'b0;
      disp_valid_q <= 1'b0;
      mv_valid_q   <= 1'b0;
      disp_data_q  <= '0;
      mv_wall_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      lat_q        <= lat_d;
      starve_q     <= starve_d;
      rom_addr_q   <= rom_addr_d;
      col_q        <= col_d;
      oor_q        <= oor_d;
      disp_gnt_q   <= disp_gnt_d;
      mv_gnt_q     <= mv_gnt_d;
      disp_valid_q <= disp_valid_d;
      mv_valid_q   <= mv_valid_d;
      disp_data_q  <= disp_data_d;
      mv_wall_q    <= mv_wall_d;
    end
  end

  assign bus.disp_gnt   = disp_gnt_q;
  assign bus.mv_gnt     = mv_gnt_q;
  assign bus.disp_valid = disp_valid_q;
  assign bus.mv_valid   = mv_valid_q;
  assign bus.disp_data  = disp_data_q;
  assign bus.mv_wall    = mv_wall_q;
  assign bus.rom_addr   = rom_addr_q;
  assign bus.busy       = state_q != IDLE;

endmodule

// File: tb/tb_maze_map_arbiter.sv
// Directed and randomized transactions against a map ROM model and a cycle-level
// expectation of grant/valid timing, results and starvation behaviour.
module tb_maze_map_arbiter;

  logic Clk;
  logic Reset;
  int   vectors;
  int   miscompares;

  logic [29:0] rom [0:19];
  logic [4:0]  last_addr;
  logic [29:0] last_data;
  logic        last_wall;

  maze_map_arbiter_if bus ();

  maze_map_arbiter dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // One-cycle synchronous map ROM.
  always @(posedge Clk) bus.rom_data <= (bus.rom_addr < 5'd20) ? rom[bus.rom_addr] : 30'd0;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_disp(input logic [4:0] row);
    logic        oor;
    logic [29:0] exp;
    oor = row >= 5'd20;
    exp = oor ? 30'h3FFF_FFFF : rom[row];
    bus.disp_row = row;
    bus.disp_req = 1'b1;
    @(negedge Clk);
    chk("disp_gnt", 32'(bus.disp_gnt), 32'd1);
    chk("disp_no_mv_gnt", 32'(bus.mv_gnt), 32'd0);
    chk("disp_busy1", 32'(bus.busy), 32'd1);
    if (!oor) last_addr = row;
    chk("disp_rom_addr", 32'(bus.rom_addr), 32'(last_addr));
    bus.disp_req = 1'b0;
    bus.disp_row = 5'($urandom_range(31, 0));
    @(negedge Clk);
    chk("disp_busy2", 32'(bus.busy), 32'd1);
    chk("disp_early_valid", 32'(bus.disp_valid), 32'd0);
    chk("disp_gnt_pulse", 32'(bus.disp_gnt), 32'd0);
    @(negedge Clk);
    chk("disp_valid", 32'(bus.disp_valid), 32'd1);
    chk("disp_data", 32'(bus.disp_data), 32'(exp));
    chk("disp_no_mv_valid", 32'(bus.mv_valid), 32'd0);
    chk("disp_wall_hold", 32'(bus.mv_wall), 32'(last_wall));
    chk("disp_idle", 32'(bus.busy), 32'd0);
    last_data = exp;
    @(negedge Clk);
    chk("disp_valid_pulse", 32'(bus.disp_valid), 32'd0);
    chk("disp_data_hold", 32'(bus.disp_data), 32'(last_data));
  endtask

  task automatic do_mv(input logic [4:0] row, input logic [4:0] col);
    logic        oor;
    logic        exp;
    logic [29:0] w;
    oor = (row >= 5'd20) || (col >= 5'd30);
    if (oor) exp = 1'b1;
    else begin
      w   = rom[row];
      exp = w[29 - int'(col)];
    end
    bus.mv_row = row;
    bus.mv_col = col;
    bus.mv_req = 1'b1;
    @(negedge Clk);
    chk("mv_gnt", 32'(bus.mv_gnt), 32'd1);
    chk("mv_no_disp_gnt", 32'(bus.disp_gnt), 32'd0);
    chk("mv_busy1", 32'(bus.busy), 32'd1);
    if (!oor) last_addr = row;
    chk("mv_rom_addr", 32'(bus.rom_addr), 32'(last_addr));
    bus.mv_req = 1'b0;
    bus.mv_col = 5'($urandom_range(31, 0));
    @(negedge Clk);
    chk("mv_busy2", 32'(bus.busy), 32'd1);
    chk("mv_early_valid", 32'(bus.mv_valid), 32'd0);
    @(negedge Clk);
    chk("mv_valid", 32'(bus.mv_valid), 32'd1);
    chk("mv_wall", 32'(bus.mv_wall), 32'(exp));
    chk("mv_no_disp_valid", 32'(bus.disp_valid), 32'd0);
    chk("mv_data_hold", 32'(bus.disp_data), 32'(last_data));
    chk("mv_idle", 32'(bus.busy), 32'd0);
    last_wall = exp;
    @(negedge Clk);
    chk("mv_valid_pulse", 32'(bus.mv_valid), 32'd0);
    chk("mv_wall_hold", 32'(bus.mv_wall), 32'(last_wall));
  endtask

  initial begin
    int          since_mv;
    logic        exp_mv;
    logic [29:0] exp_d;

    vectors     = 0;
    miscompares = 0;
    for (int r = 0; r < 20; r++) rom[r] = 30'($urandom);
    rom[3][29] = 1'b1;
    rom[3][0]  = 1'b0;
    bus.rom_data = '0;
    last_addr = '0;
    last_data = '0;
    last_wall = 1'b0;

    // Reset held with both requests pending.
    Reset        = 1'b0;
    bus.disp_req = 1'b1;
    bus.disp_row = 5'd2;
    bus.mv_req   = 1'b1;
    bus.mv_row   = 5'd1;
    bus.mv_col   = 5'd1;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      chk("rst_disp_gnt", 32'(bus.disp_gnt), 32'd0);
      chk("rst_mv_gnt", 32'(bus.mv_gnt), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_rom_addr", 32'(bus.rom_addr), 32'd0);
      chk("rst_disp_data", 32'(bus.disp_data), 32'd0);
      chk("rst_valids", 32'({bus.disp_valid, bus.mv_valid, bus.mv_wall}), 32'd0);
    end
    Reset = 1'b1;
    @(negedge Clk);
    chk("post_rst_disp_gnt", 32'(bus.disp_gnt), 32'd1);
    chk("post_rst_mv_gnt", 32'(bus.mv_gnt), 32'd0);
    bus.disp_req = 1'b0;
    bus.mv_req   = 1'b0;
    last_addr    = 5'd2;
    @(negedge Clk);
    @(negedge Clk);
    chk("post_rst_data", 32'(bus.disp_data), 32'(rom[2]));
    last_data = rom[2];
    @(negedge Clk);

    // Directed cases.
    do_disp(5'd7);
    do_mv(5'd3, 5'd0);
    do_mv(5'd3, 5'd29);
    do_disp(5'd20);
    do_mv(5'd4, 5'd30);
    do_mv(5'd21, 5'd2);
    do_disp(5'd19);

    // Both held high: four display grants, then one move grant, repeating.
    bus.disp_row = 5'd6;
    bus.mv_row   = 5'd3;
    bus.mv_col   = 5'd0;
    bus.disp_req = 1'b1;
    bus.mv_req   = 1'b1;
    since_mv     = 0;
    for (int i = 0; i < 15; i++) begin
      exp_mv = (since_mv == 4);
      since_mv = exp_mv ? 0 : since_mv + 1;
      @(negedge Clk);
      chk("starve_mv_gnt", 32'(bus.mv_gnt), 32'(exp_mv));
      chk("starve_disp_gnt", 32'(bus.disp_gnt), 32'(!exp_mv));
      @(negedge Clk);
      @(negedge Clk);
      if (exp_mv) begin
        chk("starve_mv_valid", 32'(bus.mv_valid), 32'd1);
        chk("starve_mv_wall", 32'(bus.mv_wall), 32'd1);
        last_wall = 1'b1;
      end else begin
        chk("starve_disp_valid", 32'(bus.disp_valid), 32'd1);
        chk("starve_disp_data", 32'(bus.disp_data), 32'(rom[6]));
        last_data = rom[6];
      end
      if (i == 14) begin
        bus.disp_req = 1'b0;
        bus.mv_req   = 1'b0;
      end
    end
    last_addr = 5'd3;
    @(negedge Clk);
    chk("drain_no_gnt", 32'({bus.disp_gnt, bus.mv_gnt}), 32'd0);

    // Reset in the middle of a display read drops it.
    bus.disp_row = 5'd5;
    bus.disp_req = 1'b1;
    @(negedge Clk);
    chk("mid_rst_gnt", 32'(bus.disp_gnt), 32'd1);
    bus.disp_req = 1'b0;
    @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    chk("mid_rst_valid", 32'(bus.disp_valid), 32'd0);
    chk("mid_rst_data", 32'(bus.disp_data), 32'd0);
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    Reset     = 1'b1;
    last_addr = '0;
    last_data = '0;
    last_wall = 1'b0;
    do_disp(5'd9);

    // Randomized mix of fetches and wall checks.
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(1, 0) == 1) do_disp(5'($urandom_range(23, 0)));
      else do_mv(5'($urandom_range(23, 0)), 5'($urandom_range(31, 0)));
    end

    // Starvation counter cleared by mv_req low: display wins again immediately.
    exp_d = rom[0];
    bus.disp_row = 5'd0;
    bus.disp_req = 1'b1;
    bus.mv_row   = 5'd1;
    bus.mv_col   = 5'd1;
    bus.mv_req   = 1'b1;
    @(negedge Clk);
    chk("final_disp_first", 32'(bus.disp_gnt), 32'd1);
    bus.disp_req = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    chk("final_disp_data", 32'(bus.disp_data), 32'(exp_d));
    @(negedge Clk);
    chk("final_mv_next", 32'(bus.mv_gnt), 32'd1);
    bus.mv_req = 1'b0;
    @(negedge Clk);
    @(negedge Clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/maze_map_arbiter.md
Name: maze_map_arbiter

Overview:
Shares the single synchronous maze map ROM (20 rows x 30 bits, 5-bit row address) between two requesters. The VGA renderer fetches whole rows; the player-movement logic checks one cell for a wall before committing a button-driven move. The block sits inside vga_top, between both requesters and the ROM, and owns the ROM address bus. Display requests have priority, and a starvation guard guarantees move requests are served.

Parameters:
ROWS, 20, number of map rows; row index >= ROWS is out of range
COLS, 30, bits per row (ROM data width)
ADDR_W, 5, ROM row address width
ROM_LAT, 1, ROM read latency in clocks from rom_addr to rom_data
STARVE_LIMIT, 4, consecutive display grants allowed while a move request waits

Ports:
Clk  in  1  system clock
Reset  in  1  synchronous, active-low reset
disp_req  in  1  display row-fetch request; held high until disp_gnt
disp_row  in  ADDR_W  requested row; stable while disp_req is high
disp_gnt  out  1  one-cycle grant pulse for the display requester
disp_valid  out  1  one-cycle pulse; disp_data is valid
disp_data  out  COLS  fetched row, registered
mv_req  in  1  move-check request; held high until mv_gnt
mv_row  in  ADDR_W  target cell row
mv_col  in  ADDR_W  target cell column
mv_gnt  out  1  one-cycle grant pulse for the move requester
mv_valid  out  1  one-cycle pulse; mv_wall is valid
mv_wall  out  1  1 = target cell is a wall or is out of range
rom_addr  out  ADDR_W  registered ROM row address
rom_data  in  COLS  ROM read data, available ROM_LAT clocks after rom_addr
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (Reset==0 at a rising edge): state=IDLE. All outputs 0, including disp_data, rom_addr and the starve counter. Any in-flight access is dropped and no valid pulse is issued for it. Reset takes priority over everything else.
- States: IDLE, WAIT_D, WAIT_M. The WAIT states use a latency counter loaded with ROM_LAT.
- Arbitration happens in IDLE at edge k:
  - disp_req wins unless mv_req==1 and starve==STARVE_LIMIT; in that case mv_req wins.
  - On a display win: rom_addr<=disp_row, disp_gnt=1 during cycle k+1, state<=WAIT_D.
  - On a move win: rom_addr<=mv_row, latch mv_col, mv_gnt=1 during cycle k+1, state<=WAIT_M.
- Starve counter:
  - Increments (saturating at STARVE_LIMIT) on each display grant made while mv_req==1.
  - Clears on a move grant, and on any cycle with mv_req==0.
- Completion: rom_data is captured at edge k+1+ROM_LAT. The matching valid is high during cycle k+2+ROM_LAT, and state returns to IDLE on that same edge. The next arbitration is at edge k+2+ROM_LAT, so with ROM_LAT=1 the peak rate is one access every 3 cycles.
- disp_data<=rom_data.
- mv_wall<=rom_data[COLS-1-mv_col]. Column 0 is the MSB.
- disp_data and mv_wall hold their value after the valid pulse until the next capture.
- Out-of-range requests (row>=ROWS, or col>=COLS for a move):
  - Granted as normal and the same latency is kept.
  - The ROM is not addressed; rom_addr keeps its old value.
  - Result is forced: disp_data = all ones, mv_wall = 1.
- A request dropped before its grant is ignored; no grant is issued. Changing a request's inputs after its grant has no effect.
- The grant, valid and busy pulses never overlap between the two requesters.

Decomposition:
- Shared package maze_pkg holds:
  - ROWS, COLS and ADDR_W, shared with the map ROM and the renderer.
  - STARVE_LIMIT.
  - The state encoding: IDLE=2'd0, WAIT_D=2'd1, WAIT_M=2'd2.
- No sub-module is required. The arbiter, the latency counter and the starve counter stay in one module.

Test Plan:
- Reset: Reset=0 for 3 clocks with both requests high -> all outputs 0, no grants. After Reset=1, disp_gnt follows on the next cycle.
- Single display read: disp_row=7 at edge k -> rom_addr=7 and disp_gnt=1 in cycle k+1; disp_valid=1 in cycle k+3; disp_data = ROM row 7; busy high for cycles k+1..k+2.
- Move wall check: mv_row=3, mv_col=0 on a row whose MSB is 1 -> mv_valid in cycle k+3 with mv_wall=1. The same row with mv_col=29 and LSB=0 gives mv_wall=0.
- Starvation: disp_req and mv_req both held high -> exactly 4 disp grants, then 1 mv grant, then the pattern repeats.
- Out of range: disp_row=20 -> disp_data=30'h3FFFFFFF and rom_addr unchanged. mv_col=30 -> mv_wall=1.
- Reset mid-access: Reset=0 in cycle k+2 of a display read -> no disp_valid, disp_data=0, state IDLE. The next request is served normally.
